udp_image_rx: RTL and testbench
===============================

// Module: udp_image_rx
// PURPOSE
//  Receive-side counterpart of the sobel image UDP sender: parses GMII-style Rx bytes (post RGMII DDR
//  capture) in the clk_eth domain, filters Ethernet/IPv4/UDP headers against local addresses, and
//  emits one binary image line per accepted packet as a byte stream tagged with its line number.
//  Payload = 2-byte big-endian line number + IMAGE_WIDTH/8 packed pixel bytes (MSB = leftmost pixel).
// PARAMETERS
//  IMAGE_WIDTH    1280                 pixels per line; multiple of 8
//  IMAGE_HEIGHT   720                  lines per frame; line numbers >= this are dropped
//  LOCAL_MAC      48'h00_00_00_00_00_00 accepted dest MAC (ff..ff broadcast always accepted)
//  LOCAL_IP       32'hc0_a8_00_02      accepted dest IPv4 address
//  LOCAL_UDP_PORT 16'd5000             accepted UDP dest port
//  DATA_LENGTH    IMAGE_WIDTH/8+2      required UDP payload bytes (UDP length must = DATA_LENGTH+8)
// PORTS
//  clk_eth        in   1   125 MHz Rx byte clock
//  rst_n          in   1   asynchronous reset, active low
//  rx_dv          in   1   Rx data valid (frame envelope incl. preamble/SFD/FCS)
//  rx_data        in   8   Rx byte
//  pix_data       out  8   8 packed pixels, MSB leftmost
//  pix_valid      out  1   pix_data valid
//  line_num       out  16  line number of current packet; held from line_start to next accepted packet
//  line_start     out  1   pulse with first pix_valid of a line
//  line_end       out  1   pulse with last (DATA_LENGTH-2)th pix_valid of a line
//  line_err       out  1   pulse: rx_dv dropped during PAYLOAD before line_end
//  drop_cnt       out  16  saturating count of rejected frames
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; drop_cnt 0.
//  - One byte per clk_eth while rx_dv=1; no backpressure. Outputs registered: pix_valid 1 cycle after
//    the sampled payload byte.
//  - FSM: IDLE -(rx_dv & 8'h55)-> PREAMBLE -(8'hD5)-> ETH_HDR(14B) -> IP_HDR(20B) -> UDP_HDR(8B)
//    -> LINE_NUM(2B) -> PAYLOAD(IMAGE_WIDTH/8 B) -> TAIL (ignore padding/FCS until rx_dv=0) -> IDLE.
//  - PREAMBLE: any byte other than 55/D5, or >7 bytes of 55 -> DROP.
//  - Filter, each checked at the byte completing the field; failure -> DROP, drop_cnt+1 (sat 16'hFFFF):
//    dest MAC = LOCAL_MAC or broadcast; ethertype 16'h0800; ver/IHL = 8'h45; protocol 8'd17;
//    dest IP = LOCAL_IP; UDP dest port = LOCAL_UDP_PORT; UDP length = DATA_LENGTH+8;
//    line_num < IMAGE_HEIGHT (checked before any pix_valid, so rejected lines emit nothing).
//  - DROP: wait for rx_dv=0, then IDLE. rx_dv=0 in any header state -> IDLE, drop_cnt+1, no pulses.
//  - rx_dv=0 in PAYLOAD -> line_err pulse, IDLE, no line_end; line_num retains value.
//  - rx_dv low for 1 cycle then high (min IFG violated) is treated as new frame start from IDLE.
//  - line_num updated on the cycle of line_start only; bytes beyond DATA_LENGTH never emitted.
//  - Byte counter width clog2(max(IMAGE_WIDTH/8,20)); wraps only via state reset, never arithmetically.
//  - Async reset mid-frame: immediate return to IDLE; remainder of frame handled as noise until
//    rx_dv=0 then a fresh preamble.
// CONFIGURATION
//  IP_CSUM_CHECK_EN defined: 16-bit one's-complement sum over the 20 IP header bytes; folded sum
//    != 16'hFFFF at end of IP_HDR -> DROP, drop_cnt+1. Adds no payload latency.
//  Undefined: IP header checksum ignored; accumulator not instantiated.
// STRUCTURE
//  - Package image_eth_pkg: ETHERTYPE_IPV4, IP_PROTO_UDP, ETH_HDR_LEN=14, IP_HDR_LEN=20,
//    UDP_HDR_LEN=8, PREAMBLE_BYTE, SFD_BYTE, FSM state encoding (shared with the sender).
//  - Sub-module ip_csum_acc (byte-in one's-complement accumulator, clear/en/sum_ok), only under
//    IP_CSUM_CHECK_EN. Everything else in this module.
// TESTING
//  1 Valid frame, dest IP c0a80002, port 5000, line 5, payload bytes 00..9F -> 160 pix_valid,
//    pix_data 00..9F, line_num=5, line_start on first, line_end on 160th, drop_cnt=0.
//  2 Same frame with dest port 5001 -> no pix_valid, drop_cnt=1; next valid frame accepted normally.
//  3 Line number 720 -> no output, drop_cnt+1; line 719 -> accepted, line_num=719.
//  4 rx_dv deasserted after 50 payload bytes -> 50 pix_valid, line_err pulse, no line_end, back to IDLE.
//  5 IP_CSUM_CHECK_EN: corrupt header checksum by 1 -> dropped, drop_cnt+1; undefined -> accepted.
//  6 rst_n asserted mid-payload -> outputs 0 asynchronously; after release, next full frame accepted.

Source files
------------

// File: rtl/image_eth_pkg.sv
// Shared Ethernet/IPv4/UDP constants and FSM state encoding for the sobel image
// UDP sender and receiver.
package image_eth_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;

  localparam int ETH_HDR_LEN  = 14;
  localparam int IP_HDR_LEN   = 20;
  localparam int UDP_HDR_LEN  = 8;
  localparam int LINE_NUM_LEN = 2;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         PREAMBLE_MAX  = 7;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_ETH_HDR,
    ST_IP_HDR,
    ST_UDP_HDR,
    ST_LINE_NUM,
    ST_PAYLOAD,
    ST_TAIL,
    ST_DROP
  } eth_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// Byte-serial 16-bit one's-complement accumulator for the IPv4 header checksum.
// sum_ok looks ahead through the current byte so the verdict is ready on the last header byte.
module ip_csum_acc (
  input  logic       clk_eth,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] data,
  output logic       sum_ok
);

  logic [15:0] acc_reg;
  logic [15:0] acc_next;
  logic        hi_reg;
  logic [15:0] addend;
  logic [16:0] sum_wide;

  // End-around carry cannot overflow twice: a 17-bit carry implies low half <= FFFE.
  always_comb begin
    addend   = hi_reg ? {data, 8'h00} : {8'h00, data};
    sum_wide = {1'b0, acc_reg} + {1'b0, addend};
    acc_next = acc_reg;
    if (en) begin
      acc_next = sum_wide[15:0] + {15'd0, sum_wide[16]};
    end
  end

  assign sum_ok = (acc_next == 16'hFFFF);

  always_ff @(posedge clk_eth or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= 16'h0000;
      hi_reg  <= 1'b1;
    end else if (clear) begin
      acc_reg <= 16'h0000;
      hi_reg  <= 1'b1;
    end else if (en) begin
      acc_reg <= acc_next;
      hi_reg  <= ~hi_reg;
    end
  end

endmodule

// File: rtl/udp_image_rx.sv
// GMII-style Rx parser: filters Ethernet/IPv4/UDP headers and streams one packed binary image
// line per accepted packet. Define IP_CSUM_CHECK_EN to enforce the IPv4 header checksum.
module udp_image_rx
  import image_eth_pkg::*;
#(
  parameter int          IMAGE_WIDTH    = 1280,
  parameter int          IMAGE_HEIGHT   = 720,
  parameter logic [47:0] LOCAL_MAC      = 48'h00_00_00_00_00_00,
  parameter logic [31:0] LOCAL_IP       = 32'hc0_a8_00_02,
  parameter logic [15:0] LOCAL_UDP_PORT = 16'd5000,
  parameter int          DATA_LENGTH    = IMAGE_WIDTH / 8 + 2
) (
  input  logic        clk_eth,
  input  logic        rst_n,
  input  logic        rx_dv,
  input  logic [7:0]  rx_data,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  output logic [15:0] line_num,
  output logic        line_start,
  output logic        line_end,
  output logic        line_err,
  output logic [15:0] drop_cnt
);

  localparam int          PIX_BYTES   = IMAGE_WIDTH / 8;
  localparam int          CNT_W       = $clog2(max_int(PIX_BYTES, IP_HDR_LEN));
  localparam logic [15:0] UDP_LEN_EXP = 16'(DATA_LENGTH + UDP_HDR_LEN);

  // Byte index (within the current header) completing each filtered field.
  localparam int MAC_LAST_IDX   = 5;
  localparam int IP_VER_IDX     = 0;
  localparam int IP_PROTO_IDX   = 9;
  localparam int UDP_DPORT_LAST = 3;
  localparam int UDP_LEN_LAST   = 5;

  eth_state_t        state_reg, state_next;
  eth_state_t        hdr_after;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [2:0]        pre_cnt_reg, pre_cnt_next;
  logic [39:0]       sh_reg;
  logic [15:0]       pend_line_reg, pend_line_next;
  logic [7:0]        pix_data_reg, pix_data_next;
  logic              pix_valid_reg, pix_valid_next;
  logic [15:0]       line_num_reg, line_num_next;
  logic              line_start_reg, line_start_next;
  logic              line_end_reg, line_end_next;
  logic              line_err_reg, line_err_next;
  logic [15:0]       drop_cnt_reg;
  logic              drop_inc;
  logic              hdr_last, hdr_bad, hdr_state;
  logic              csum_ok;
  logic              mac_ok;
  logic [15:0]       f16;
  logic [31:0]       f32;
  logic [47:0]       f48;
  int                idx;

  assign idx    = int'(cnt_reg);
  assign f16    = {sh_reg[7:0], rx_data};
  assign f32    = {sh_reg[23:0], rx_data};
  assign f48    = {sh_reg[39:0], rx_data};
  assign mac_ok = (f48 == LOCAL_MAC) || (f48 == '1);

`ifdef IP_CSUM_CHECK_EN
  ip_csum_acc u_ip_csum_acc (
    .clk_eth (clk_eth),
    .rst_n   (rst_n),
    .clear   (state_reg != ST_IP_HDR),
    .en      ((state_reg == ST_IP_HDR) && rx_dv),
    .data    (rx_data),
    .sum_ok  (csum_ok)
  );
`else
  assign csum_ok = 1'b1;
`endif

  assign hdr_state = (state_reg == ST_ETH_HDR) || (state_reg == ST_IP_HDR) ||
                     (state_reg == ST_UDP_HDR) || (state_reg == ST_LINE_NUM);

  // Per-header field filter, evaluated on the byte that completes each field.
  always_comb begin
    hdr_last  = 1'b0;
    hdr_bad   = 1'b0;
    hdr_after = ST_IDLE;
    case (state_reg)
      ST_ETH_HDR: begin
        hdr_last  = (idx == ETH_HDR_LEN - 1);
        hdr_after = ST_IP_HDR;
        hdr_bad   = ((idx == MAC_LAST_IDX) && !mac_ok) ||
                    (hdr_last && (f16 != ETHERTYPE_IPV4));
      end
      ST_IP_HDR: begin
        hdr_last  = (idx == IP_HDR_LEN - 1);
        hdr_after = ST_UDP_HDR;
        hdr_bad   = ((idx == IP_VER_IDX) && (rx_data != IP_VER_IHL)) ||
                    ((idx == IP_PROTO_IDX) && (rx_data != IP_PROTO_UDP)) ||
                    (hdr_last && ((f32 != LOCAL_IP) || !csum_ok));
      end
      ST_UDP_HDR: begin
        hdr_last  = (idx == UDP_HDR_LEN - 1);
        hdr_after = ST_LINE_NUM;
        hdr_bad   = ((idx == UDP_DPORT_LAST) && (f16 != LOCAL_UDP_PORT)) ||
                    ((idx == UDP_LEN_LAST) && (f16 != UDP_LEN_EXP));
      end
      ST_LINE_NUM: begin
        hdr_last  = (idx == LINE_NUM_LEN - 1);
        hdr_after = ST_PAYLOAD;
        hdr_bad   = hdr_last && (int'(f16) >= IMAGE_HEIGHT);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    pre_cnt_next    = pre_cnt_reg;
    pend_line_next  = pend_line_reg;
    line_num_next   = line_num_reg;
    pix_data_next   = 8'h00;
    pix_valid_next  = 1'b0;
    line_start_next = 1'b0;
    line_end_next   = 1'b0;
    line_err_next   = 1'b0;
    drop_inc        = 1'b0;

    if (hdr_state) begin
      if (!rx_dv) begin
        state_next = ST_IDLE;
        drop_inc   = 1'b1;
      end else if (hdr_bad) begin
        state_next = ST_DROP;
        drop_inc   = 1'b1;
      end else if (hdr_last) begin
        state_next = hdr_after;
        cnt_next   = '0;
        if (state_reg == ST_LINE_NUM) begin
          pend_line_next = f16;
        end
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (rx_dv) begin
            if (rx_data == PREAMBLE_BYTE) begin
              state_next   = ST_PREAMBLE;
              pre_cnt_next = 3'd1;
            end else begin
              state_next = ST_DROP;
            end
          end
        end
        ST_PREAMBLE: begin
          if (!rx_dv) begin
            state_next = ST_IDLE;
          end else if (rx_data == SFD_BYTE) begin
            state_next = ST_ETH_HDR;
            cnt_next   = '0;
          end else if ((rx_data == PREAMBLE_BYTE) && (pre_cnt_reg < 3'(PREAMBLE_MAX))) begin
            pre_cnt_next = pre_cnt_reg + 3'd1;
          end else begin
            state_next = ST_DROP;
          end
        end
        ST_PAYLOAD: begin
          if (!rx_dv) begin
            state_next    = ST_IDLE;
            line_err_next = 1'b1;
          end else begin
            pix_valid_next = 1'b1;
            pix_data_next  = rx_data;
            if (idx == 0) begin
              line_start_next = 1'b1;
              line_num_next   = pend_line_reg;
            end
            if (idx == PIX_BYTES - 1) begin
              line_end_next = 1'b1;
              state_next    = ST_TAIL;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
        end
        ST_TAIL, ST_DROP: begin
          if (!rx_dv) begin
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_eth or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      pre_cnt_reg    <= 3'd0;
      sh_reg         <= 40'd0;
      pend_line_reg  <= 16'd0;
      pix_data_reg   <= 8'h00;
      pix_valid_reg  <= 1'b0;
      line_num_reg   <= 16'd0;
      line_start_reg <= 1'b0;
      line_end_reg   <= 1'b0;
      line_err_reg   <= 1'b0;
      drop_cnt_reg   <= 16'd0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      pre_cnt_reg    <= pre_cnt_next;
      pend_line_reg  <= pend_line_next;
      pix_data_reg   <= pix_data_next;
      pix_valid_reg  <= pix_valid_next;
      line_num_reg   <= line_num_next;
      line_start_reg <= line_start_next;
      line_end_reg   <= line_end_next;
      line_err_reg   <= line_err_next;
      if (rx_dv) begin
        sh_reg <= {sh_reg[31:0], rx_data};
      end
      if (drop_inc && (drop_cnt_reg != 16'hFFFF)) begin
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
    end
  end

  assign pix_data   = pix_data_reg;
  assign pix_valid  = pix_valid_reg;
  assign line_num   = line_num_reg;
  assign line_start = line_start_reg;
  assign line_end   = line_end_reg;
  assign line_err   = line_err_reg;
  assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_udp_image_rx.sv
// Directed bench for udp_image_rx: builds whole Rx frames, predicts acceptance with a header
// model and scoreboards every emitted pixel byte.
module tb_udp_image_rx;

  logic        clk_eth = 1'b0;
  logic        rst_n;
  logic        rx_dv;
  logic [7:0]  rx_data;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic [15:0] line_num;
  logic        line_start;
  logic        line_end;
  logic        line_err;
  logic [15:0] drop_cnt;

  udp_image_rx dut (
    .clk_eth    (clk_eth),
    .rst_n      (rst_n),
    .rx_dv      (rx_dv),
    .rx_data    (rx_data),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .line_num   (line_num),
    .line_start (line_start),
    .line_end   (line_end),
    .line_err   (line_err),
    .drop_cnt   (drop_cnt)
  );

  always #4 clk_eth = ~clk_eth;

  typedef struct packed {
    logic [7:0]  d;
    logic [15:0] ln;
    logic        s;
    logic        e;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   n_pix = 0, n_start = 0, n_end = 0, n_err = 0;
  int   exp_drop = 0;
  logic [15:0] exp_line = 16'd0;

  // frame fields, set by set_defaults() and tweaked per step
  logic [47:0] f_mac;
  logic [15:0] f_etype, f_dport, f_ulen, f_line;
  logic [7:0]  f_vihl, f_proto;
  logic [31:0] f_dip;
  bit          f_bad_csum, f_rst_mid;
  int          f_cut, f_gap, f_pat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk_eth) begin
    if (pix_valid) begin
      n_pix++;
      if (sb.size() == 0) begin
        chk("pix_unexpected", 32'(pix_valid), 32'h0);
      end else begin
        mon_e = sb.pop_front();
        chk("pix", {6'b0, pix_data, line_num, line_start, line_end},
                   {6'b0, mon_e.d, mon_e.ln, mon_e.s, mon_e.e});
      end
    end
    if (line_start) n_start++;
    if (line_end)   n_end++;
    if (line_err)   n_err++;
  end

  function automatic logic [15:0] ip_csum(input logic [7:0] h [20]);
    logic [31:0] s = 32'd0;
    for (int i = 0; i < 20; i += 2) s += {16'd0, h[i], h[i+1]};
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    return ~s[15:0];
  endfunction

  task automatic set_defaults();
    f_mac = 48'h00_00_00_00_00_00; f_etype = 16'h0800; f_vihl = 8'h45; f_proto = 8'd17;
    f_dip = 32'hc0a80002; f_dport = 16'd5000; f_ulen = 16'd170; f_line = 16'd0;
    f_bad_csum = 1'b0; f_rst_mid = 1'b0; f_cut = 0; f_gap = 12; f_pat = 0;
  endtask

  task automatic tick();
    @(posedge clk_eth);
    #1;
  endtask

  task automatic send_frame(input string name);
    logic [7:0]  fr[$];
    logic [7:0]  ip[20];
    logic [15:0] cs;
    exp_t        e;
    int          n, npix, s0, e0, r0, p0;
    bit          hdr_ok, acc_hdr;
    fr = {};
    repeat (7) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    for (int i = 0; i < 6; i++) fr.push_back(f_mac[47-8*i -: 8]);
    fr.push_back(8'h02); for (int i = 0; i < 4; i++) fr.push_back(8'h00); fr.push_back(8'h01);
    fr.push_back(f_etype[15:8]); fr.push_back(f_etype[7:0]);
    ip = '{f_vihl, 8'h00, 8'h00, 8'hBE, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, f_proto,
           8'h00, 8'h00, 8'hc0, 8'ha8, 8'h00, 8'h01,
           f_dip[31:24], f_dip[23:16], f_dip[15:8], f_dip[7:0]};
    cs = ip_csum(ip) + (f_bad_csum ? 16'd1 : 16'd0);
    ip[10] = cs[15:8]; ip[11] = cs[7:0];
    for (int i = 0; i < 20; i++) fr.push_back(ip[i]);
    fr.push_back(8'h04); fr.push_back(8'hD2);
    fr.push_back(f_dport[15:8]); fr.push_back(f_dport[7:0]);
    fr.push_back(f_ulen[15:8]); fr.push_back(f_ulen[7:0]);
    fr.push_back(8'h00); fr.push_back(8'h00);
    fr.push_back(f_line[15:8]); fr.push_back(f_line[7:0]);
    for (int k = 0; k < 160; k++) fr.push_back((f_pat == 0) ? 8'(k) : 8'(k * 7 + f_pat));
    fr.push_back(8'hDE); fr.push_back(8'hAD); fr.push_back(8'hBE); fr.push_back(8'hEF);

    hdr_ok = ((f_mac == 48'h0) || (f_mac == 48'hFFFF_FFFF_FFFF)) && (f_etype == 16'h0800) &&
             (f_vihl == 8'h45) && (f_proto == 8'd17) && (f_dip == 32'hc0a80002) &&
             (f_dport == 16'd5000) && (f_ulen == 16'd170) && (f_line < 16'd720);
`ifdef IP_CSUM_CHECK_EN
    hdr_ok = hdr_ok && !f_bad_csum;
`endif
    n       = (f_cut > 0) ? f_cut : fr.size();
    npix    = (n <= 52) ? 0 : ((n - 52 > 160) ? 160 : n - 52);
    acc_hdr = hdr_ok && (n >= 52);
    s0 = n_start; e0 = n_end; r0 = n_err; p0 = n_pix;

    for (int i = 0; i < n; i++) begin
      rx_dv = 1'b1;
      rx_data = fr[i];
      if (acc_hdr && i >= 52 && i < 212) begin
        e.d = fr[i]; e.ln = f_line; e.s = (i == 52); e.e = (i == 211);
        sb.push_back(e);
      end
      tick();
    end

    if (f_rst_mid) begin
      @(negedge clk_eth);
      #1 rst_n = 1'b0;
      #1;
      chk({name, "_rst_pix_valid"}, 32'(pix_valid), 32'h0);
      chk({name, "_rst_pix_data"}, 32'(pix_data), 32'h0);
      chk({name, "_rst_line_num"}, 32'(line_num), 32'h0);
      exp_drop = 0;
      exp_line = 16'd0;
      rx_data = 8'hC3;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (4) tick();
    end else begin
      if (!acc_hdr) exp_drop++;
      if (acc_hdr && npix > 0) exp_line = f_line;
    end
    rx_dv = 1'b0;
    rx_data = 8'h00;
    repeat (f_gap) tick();

    $display("frame %s line=%0d bytes=%0d exp_pix=%0d drop_cnt=%0d line_num=%0d",
             name, f_line, n, acc_hdr ? npix : 0, drop_cnt, line_num);
    chk({name, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
    chk({name, "_line_num"}, 32'(line_num), 32'(exp_line));
    chk({name, "_sb_left"}, 32'(sb.size()), 32'h0);
    chk({name, "_pix_count"}, 32'(n_pix - p0), 32'(acc_hdr ? npix : 0));
    chk({name, "_start_count"}, 32'(n_start - s0), 32'(acc_hdr && npix > 0));
    chk({name, "_end_count"}, 32'(n_end - e0), 32'(acc_hdr && npix == 160));
    chk({name, "_err_count"}, 32'(n_err - r0), 32'(acc_hdr && npix < 160 && !f_rst_mid));
    sb.delete();
  endtask

  initial begin
    rst_n = 1'b0; rx_dv = 1'b0; rx_data = 8'h00;
    repeat (3) tick();
    chk("reset_pix_valid", 32'(pix_valid), 32'h0);
    chk("reset_pix_data", 32'(pix_data), 32'h0);
    chk("reset_line_num", 32'(line_num), 32'h0);
    chk("reset_line_start", 32'(line_start), 32'h0);
    chk("reset_line_end", 32'(line_end), 32'h0);
    chk("reset_line_err", 32'(line_err), 32'h0);
    chk("reset_drop_cnt", 32'(drop_cnt), 32'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    set_defaults(); f_line = 16'd5;                    send_frame("valid_line5");
    set_defaults(); f_dport = 16'd5001;                send_frame("bad_port");
    set_defaults(); f_line = 16'd6;  f_pat = 3;        send_frame("valid_line6");
    set_defaults(); f_line = 16'd720;                  send_frame("line720");
    set_defaults(); f_line = 16'd719; f_pat = 11;      send_frame("line719");
    set_defaults(); f_line = 16'd10; f_cut = 52 + 50;  send_frame("trunc_payload");
    set_defaults(); f_line = 16'd11; f_bad_csum = 1'b1; send_frame("bad_csum");
    set_defaults(); f_line = 16'd12; f_mac = 48'hFFFF_FFFF_FFFF; f_gap = 1; send_frame("bcast_short_ifg");
    set_defaults(); f_line = 16'd13; f_pat = 5;        send_frame("after_short_ifg");
    set_defaults(); f_mac = 48'h02_00_00_00_00_09;     send_frame("bad_mac");
    set_defaults(); f_etype = 16'h86DD;                send_frame("bad_ethertype");
    set_defaults(); f_proto = 8'd6;                    send_frame("bad_proto");
    set_defaults(); f_ulen = 16'd171;                  send_frame("bad_udp_len");
    set_defaults(); f_cut = 30;                        send_frame("trunc_header");
    set_defaults(); f_line = 16'd20; f_cut = 52 + 30; f_rst_mid = 1'b1; send_frame("reset_mid");
    set_defaults(); f_line = 16'd21; f_pat = 9;        send_frame("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
